// File: rtl/butterfly_noc_pkg.sv
// butterfly_noc_pkg: shared address width, flit type codes and head-field layout for the butterfly NoC
package butterfly_noc_pkg;
  localparam int ADDR_W = 3;
  localparam int DEST_LSB = 0;
  localparam int SRC_LSB = 3;
  localparam int SEQ_LSB = 6;
  localparam int SEQ_W = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, HEAD = 2'b01, BODY = 2'b10, TAIL = 2'b11} flit_type_t;
  typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY, ST_TAIL} ni_state_t;
endpackage

// File: rtl/ni_msg_fifo.sv
// ni_msg_fifo: synchronous message FIFO with asynchronous active-low reset
module ni_msg_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign count = wp - rp;
  assign full = count == PW'(DEPTH);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + PW'(1);
      if (pop && !empty) rp <= rp + PW'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/butterfly_ni_tx.sv
// butterfly_ni_tx: injection NI serializing queued messages into credit-paced HEAD/BODY/TAIL flits.
// Define NI_FLIT_PARITY_EN to build a registered even-parity bit alongside each flit.
module butterfly_ni_tx
  import butterfly_noc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_ADDR = 3'b000,
  parameter int DATA_W = 32,
  parameter int PKT_WORDS = 2,
  parameter int DEPTH = 4,
  parameter int CREDITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        msg_valid,
  output logic                        msg_ready,
  input  logic [ADDR_W-1:0]           msg_dest,
  input  logic [DATA_W*PKT_WORDS-1:0] msg_data,
  output logic                        flit_valid,
  output logic [DATA_W+1:0]           flit,
  output logic                        flit_par,
  input  logic                        credit_in,
  output logic                        credit_err
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int MW = ADDR_W + DATA_W * PKT_WORDS;
  localparam int NW = $clog2(DEPTH) + 1;
  ni_state_t state, cur, nxt;
  flit_type_t ftype;
  logic [CW-1:0] credits;
  logic [SEQ_W-1:0] seq;
  logic [1:0] widx, wsel;
  logic [MW-1:0] qmsg;
  logic [NW-1:0] count;
  logic [DATA_W-1:0] hdr, word;
  logic [DATA_W+1:0] flit_d;
  logic full, empty, push, pop, send, at_max;
  assign msg_ready = !full;
  assign push = msg_valid && !full;
  assign at_max = credits == CW'(CREDITS);
  ni_msg_fifo #(.W(MW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din({msg_dest, msg_data}),
    .dout(qmsg), .full(full), .empty(empty), .count(count)
  );
  // An idle FSM with a queued message acts as SEND_HEAD, so the HEAD leaves one edge after enqueue
  assign cur = (state == ST_IDLE && !empty) ? ST_HEAD : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= nxt;
  always_comb
    nxt = !send ? cur :
          cur == ST_HEAD ? (PKT_WORDS > 1 ? ST_BODY : ST_TAIL) :
          cur == ST_BODY ? (widx == 2'(PKT_WORDS - 2) ? ST_TAIL : ST_BODY) :
          (count > NW'(1) || push) ? ST_HEAD : ST_IDLE;
  always_comb begin
    send = cur != ST_IDLE && credits != '0;
    pop = send && cur == ST_TAIL;
    hdr = '0;
    hdr[DEST_LSB +: ADDR_W] = qmsg[MW-1 -: ADDR_W];
    hdr[SRC_LSB +: ADDR_W] = SRC_ADDR;
    hdr[SEQ_LSB +: SEQ_W] = seq;
    wsel = cur == ST_TAIL ? 2'(PKT_WORDS - 1) : widx;
    word = qmsg[DATA_W*wsel +: DATA_W];
    ftype = cur == ST_HEAD ? HEAD : cur == ST_BODY ? BODY : TAIL;
    flit_d = send ? {ftype, cur == ST_HEAD ? hdr : word} : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      flit_valid <= 1'b0;
      flit <= '0;
      credits <= CW'(CREDITS);
      credit_err <= 1'b0;
      seq <= '0;
      widx <= '0;
    end else begin
      flit_valid <= send;
      flit <= flit_d;
      if (send && !credit_in) credits <= credits - CW'(1);
      else if (!send && credit_in && !at_max) credits <= credits + CW'(1);
      if (!send && credit_in && at_max) credit_err <= 1'b1;
      if (send && cur == ST_HEAD) seq <= seq + SEQ_W'(1);
      if (send) widx <= cur == ST_BODY ? widx + 2'd1 : 2'd0;
    end
`ifdef NI_FLIT_PARITY_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) flit_par <= 1'b0;
    else flit_par <= ^flit_d;
`else
  assign flit_par = 1'b0;
`endif
endmodule

// File: tb/tb_butterfly_ni_tx.sv
// tb_butterfly_ni_tx: directed self-checking bench for butterfly_ni_tx (SRC_ADDR=3'b010, defaults otherwise)
module tb_butterfly_ni_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic msg_valid = 1'b0;
  logic msg_ready;
  logic [2:0] msg_dest = '0;
  logic [63:0] msg_data = '0;
  logic flit_valid;
  logic [33:0] flit;
  logic flit_par;
  logic credit_in = 1'b0;
  logic credit_err;
  int n_cmp = 0;
  int n_err = 0;
  int nflits, pushed, heads, cyc;

  butterfly_ni_tx #(.SRC_ADDR(3'b010)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_dest(msg_dest), .msg_data(msg_data), .flit_valid(flit_valid), .flit(flit),
    .flit_par(flit_par), .credit_in(credit_in), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flit(input string tag, input logic v, input logic [33:0] f);
    logic ep;
`ifdef NI_FLIT_PARITY_EN
    ep = ^f;
`else
    ep = 1'b0;
`endif
    chk({tag, "_valid"}, 64'(flit_valid), 64'(v));
    chk({tag, "_flit"}, 64'(flit), 64'(f));
    chk({tag, "_par"}, 64'(flit_par), 64'(ep));
  endtask

  task automatic do_reset();
    msg_valid = 1'b0;
    credit_in = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_ready", 64'(msg_ready), 64'd1);
    chk("rst_err", 64'(credit_err), 64'd0);
    chk_flit("rst", 1'b0, 34'h0);
    tick();
    rst = 1'b1;
    // basic packet: HEAD dest=5 src=2 seq=0, BODY word0, TAIL word1
    msg_valid = 1'b1;
    msg_dest = 3'b101;
    msg_data = 64'hA5A5_0001_DEAD_BEEF;
    tick();
    msg_valid = 1'b0;
    chk_flit("enq_edge", 1'b0, 34'h0);
    tick();
    chk_flit("head0", 1'b1, {2'b01, 32'h0000_0015});
    tick();
    chk_flit("body0", 1'b1, {2'b10, 32'hDEAD_BEEF});
    tick();
    chk_flit("tail0", 1'b1, {2'b11, 32'hA5A5_0001});
    tick();
    chk_flit("idle0", 1'b0, 34'h0);
    // one credit left: a credit returned while sending keeps it at 1
    msg_valid = 1'b1;
    msg_dest = 3'b001;
    msg_data = 64'h0000_0002_0000_0001;
    tick();
    msg_valid = 1'b0;
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk_flit("head1", 1'b1, {2'b01, 32'h0000_0051});
    tick();
    chk_flit("body1", 1'b1, {2'b10, 32'h0000_0001});
    tick();
    chk_flit("stall1", 1'b0, 34'h0);
    tick();
    chk_flit("stall2", 1'b0, 34'h0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk_flit("credit_edge", 1'b0, 34'h0);
    tick();
    chk_flit("tail1", 1'b1, {2'b11, 32'h0000_0002});
    tick();
    chk_flit("idle1", 1'b0, 34'h0);
    // refill to CREDITS, then one more overflows
    credit_in = 1'b1;
    repeat (4) tick();
    chk("err_at_max", 64'(credit_err), 64'd0);
    tick();
    credit_in = 1'b0;
    chk("err_set", 64'(credit_err), 64'd1);
    tick();
    tick();
    chk("err_sticky", 64'(credit_err), 64'd1);
    chk_flit("err_idle", 1'b0, 34'h0);
    rst = 1'b0;
    #1;
    chk("err_reset", 64'(credit_err), 64'd0);
    tick();
    rst = 1'b1;
    // five messages without credit returns
    nflits = 0;
    for (int i = 0; i < 5; i++) begin
      msg_valid = 1'b1;
      msg_dest = 3'(i);
      msg_data = {32'(i + 100), 32'(i)};
      chk("fill_ready", 64'(msg_ready), 64'd1);
      tick();
      nflits += int'(flit_valid);
    end
    msg_valid = 1'b0;
    chk("full_ready", 64'(msg_ready), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      nflits += int'(flit_valid);
    end
    chk("fill_flits", 64'(nflits), 64'd4);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk_flit("ret_edge", 1'b0, 34'h0);
    tick();
    chk_flit("ret_body", 1'b1, {2'b10, 32'd1});
    tick();
    chk_flit("ret_after", 1'b0, 34'h0);
    do_reset();
    // 257 packets with immediate credit return: seq 0..255 then 0
    pushed = 0;
    heads = 0;
    cyc = 0;
    while (heads < 257 && cyc < 3000) begin
      msg_valid = pushed < 257;
      msg_dest = 3'(pushed);
      msg_data = {32'(pushed), ~32'(pushed)};
      if (msg_valid && msg_ready) pushed++;
      credit_in = flit_valid;
      tick();
      cyc++;
      if (flit_valid && flit[33:32] == 2'b01) begin
        chk("seq", 64'(flit[13:6]), 64'(heads & 255));
        heads++;
      end
    end
    chk("heads", 64'(heads), 64'd257);
    // queue one more message, then reset right after the BODY flit
    msg_valid = 1'b1;
    msg_dest = 3'b111;
    credit_in = flit_valid;
    tick();
    msg_valid = 1'b0;
    credit_in = 1'b0;
    chk("pre_rst_body", 64'({flit_valid, flit[33:32]}), 64'({1'b1, 2'b10}));
    rst = 1'b0;
    #1;
    chk_flit("mid_rst", 1'b0, 34'h0);
    chk("mid_rst_ready", 64'(msg_ready), 64'd1);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_flit("post_rst_idle", 1'b0, 34'h0);
    end
    msg_valid = 1'b1;
    msg_dest = 3'b011;
    msg_data = 64'h1111_2222_3333_4444;
    tick();
    msg_valid = 1'b0;
    tick();
    chk_flit("head_r", 1'b1, {2'b01, 32'h0000_0013});
    tick();
    chk_flit("body_r", 1'b1, {2'b10, 32'h3333_4444});
    tick();
    chk_flit("tail_r", 1'b1, {2'b11, 32'h1111_2222});
    tick();
    chk_flit("idle_r", 1'b0, 34'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
